// File: rtl/dmem_arbiter.sv
// Two-requester data-memory controller: arbitrates CPU vs external port,
// sequences one access at a time and performs read-modify-write for
// byte/halfword stores on a big-endian, word-wide memory.
module dmem_arbiter #(
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_size,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_resp_valid,
    output logic              cpu_resp_err,
    output logic [31:0]       cpu_rdata,

    input  logic              ext_valid,
    output logic              ext_ready,
    input  logic              ext_we,
    input  logic [1:0]        ext_size,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [31:0]       ext_wdata,
    output logic              ext_resp_valid,
    output logic              ext_resp_err,
    output logic [31:0]       ext_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RMW_RD = 3'd2,
        WR     = 3'd3,
        RESP   = 3'd4
    } state_t;

    typedef struct packed {
        logic              we;
        logic [1:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    // Illegal size or misaligned halfword/word access.
    function automatic logic req_err(input logic [1:0] size, input logic [1:0] a);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = a[0];
            SZ_WORD: bad = (a != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Pull the addressed big-endian lane out of a memory word, right-aligned.
    function automatic logic [DATA_W-1:0] lane_extract(input logic [DATA_W-1:0] word,
                                                       input logic [1:0]        size,
                                                       input logic [1:0]        a);
        logic [DATA_W-1:0] res;
        res = '0;
        case (size)
            SZ_BYTE: begin
                case (a)
                    2'd0:    res = {24'd0, word[31:24]};
                    2'd1:    res = {24'd0, word[23:16]};
                    2'd2:    res = {24'd0, word[15:8]};
                    default: res = {24'd0, word[7:0]};
                endcase
            end
            SZ_HALF: res = a[1] ? {16'd0, word[15:0]} : {16'd0, word[31:16]};
            SZ_WORD: res = word;
            default: res = '0;
        endcase
        return res;
    endfunction

    // Insert right-aligned store data into the addressed lane of an old word.
    function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] old,
                                                     input logic [DATA_W-1:0] data,
                                                     input logic [1:0]        size,
                                                     input logic [1:0]        a);
        logic [DATA_W-1:0] res;
        res = old;
        case (size)
            SZ_BYTE: begin
                case (a)
                    2'd0:    res[31:24] = data[7:0];
                    2'd1:    res[23:16] = data[7:0];
                    2'd2:    res[15:8]  = data[7:0];
                    default: res[7:0]   = data[7:0];
                endcase
            end
            SZ_HALF: begin
                if (a[1]) res[15:0]  = data[15:0];
                else      res[31:16] = data[15:0];
            end
            default: res = data;
        endcase
        return res;
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_starve;
    logic               r_owner;        // 0 = cpu, 1 = ext
    logic [1:0]         r_size;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_word;         // store data, then merged write word

    logic               w_grant_cpu;
    logic               w_grant_ext;
    logic               w_accept;
    req_t               w_sel;
    logic               w_sel_err;
    logic [ADDR_W-1:0]  w_word_addr;
    logic               w_enter_resp;
    logic               w_owner_nxt;
    logic               w_resp_err;
    logic [DATA_W-1:0]  w_resp_data;

    // Arbitration: CPU has priority unless ext has lost STARVE_LIMIT times in a row.
    assign w_grant_ext = rst && (r_state == IDLE) && ext_valid
                         && (!cpu_valid || (r_starve == LIMIT));
    assign w_grant_cpu = rst && (r_state == IDLE) && cpu_valid && !w_grant_ext;
    assign w_accept    = w_grant_cpu || w_grant_ext;

    assign w_sel = w_grant_ext ? req_t'{ext_we, ext_size, ext_addr, ext_wdata}
                               : req_t'{cpu_we, cpu_size, cpu_addr, cpu_wdata};
    assign w_sel_err   = req_err(w_sel.size, w_sel.addr[1:0]);
    assign w_word_addr = {r_addr[ADDR_W-1:2], 2'b00};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state logic, grant strobes and memory-port drive.
    always_comb begin
        w_state_nxt = r_state;
        cpu_ready   = 1'b0;
        ext_ready   = 1'b0;
        mem_addr    = '0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        mem_wdata   = '0;
        case (r_state)
            IDLE: begin
                cpu_ready = w_grant_cpu;
                ext_ready = w_grant_ext;
                if (w_accept) begin
                    if (w_sel_err)                 w_state_nxt = RESP;
                    else if (!w_sel.we)            w_state_nxt = RD;
                    else if (w_sel.size == SZ_WORD) w_state_nxt = WR;
                    else                           w_state_nxt = RMW_RD;
                end
            end
            RD: begin
                mem_addr    = w_word_addr;
                mem_rd      = 1'b1;
                w_state_nxt = RESP;
            end
            RMW_RD: begin
                mem_addr    = w_word_addr;
                mem_rd      = 1'b1;
                w_state_nxt = WR;
            end
            WR: begin
                mem_addr    = w_word_addr;
                mem_wr      = 1'b1;
                mem_wdata   = r_word;
                w_state_nxt = RESP;
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Starvation counter: counts consecutive arbitrations ext lost while waiting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve <= '0;
        end else if (!ext_valid || w_grant_ext) begin
            r_starve <= '0;
        end else if (w_grant_cpu && (r_starve != LIMIT)) begin
            r_starve <= r_starve + CNT_W'(1);
        end
    end

    // Request latch on accept; RMW merge of the fetched word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner <= 1'b0;
            r_size  <= '0;
            r_addr  <= '0;
            r_word  <= '0;
        end else if (w_accept) begin
            r_owner <= w_grant_ext;
            r_size  <= w_sel.size;
            r_addr  <= w_sel.addr;
            r_word  <= w_sel.wdata;
        end else if (r_state == RMW_RD) begin
            r_word  <= lane_merge(mem_rdata, r_word, r_size, r_addr[1:0]);
        end
    end

    assign w_enter_resp = (w_state_nxt == RESP) && (r_state != RESP);
    assign w_owner_nxt  = (r_state == IDLE) ? w_grant_ext : r_owner;
    assign w_resp_err   = (r_state == IDLE) && w_sel_err;
    assign w_resp_data  = (r_state == RD) ? lane_extract(mem_rdata, r_size, r_addr[1:0])
                                          : '0;

    // Registered completion: pulse valid/err for one cycle, hold rdata until next response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_resp_valid <= 1'b0;
            cpu_resp_err   <= 1'b0;
            cpu_rdata      <= '0;
            ext_resp_valid <= 1'b0;
            ext_resp_err   <= 1'b0;
            ext_rdata      <= '0;
        end else begin
            cpu_resp_valid <= 1'b0;
            cpu_resp_err   <= 1'b0;
            ext_resp_valid <= 1'b0;
            ext_resp_err   <= 1'b0;
            if (w_enter_resp) begin
                if (w_owner_nxt) begin
                    ext_resp_valid <= 1'b1;
                    ext_resp_err   <= w_resp_err;
                    ext_rdata      <= w_resp_data;
                end else begin
                    cpu_resp_valid <= 1'b1;
                    cpu_resp_err   <= w_resp_err;
                    cpu_rdata      <= w_resp_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized + directed bench for dmem_arbiter with a byte-array reference
// model, an arbitration model and a per-requester response scoreboard.
module tb_dmem_arbiter;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned LIMIT  = 4;

    logic              clk;
    logic              rst;
    logic              cpu_valid, cpu_ready, cpu_we, cpu_resp_valid, cpu_resp_err;
    logic [1:0]        cpu_size;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata, cpu_rdata;
    logic              ext_valid, ext_ready, ext_we, ext_resp_valid, ext_resp_err;
    logic [1:0]        ext_size;
    logic [ADDR_W-1:0] ext_addr;
    logic [31:0]       ext_wdata, ext_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd, mem_wr;
    logic [31:0]       mem_wdata, mem_rdata;

    dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_we(cpu_we),
        .cpu_size(cpu_size), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_err(cpu_resp_err), .cpu_rdata(cpu_rdata),
        .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_we(ext_we),
        .ext_size(ext_size), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_resp_valid(ext_resp_valid), .ext_resp_err(ext_resp_err), .ext_rdata(ext_rdata),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    typedef struct { logic [31:0] data; logic err; int cyc; } exp_t;
    typedef struct { logic [31:0] data; logic err; int lat; } res_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    exp_t        q_cpu[$];
    exp_t        q_ext[$];
    logic [7:0]  ref_mem [32];
    logic [31:0] mem_words [8];
    logic        preload;
    logic [4:0]  last_wr_addr;
    logic [31:0] last_wr_data;
    int          wr_count = 0;
    int          idle_at = 0;
    int          starve = 0;
    int          n_acc [2];
    int          acc_cyc [2];
    logic        prev_wr;
    logic [31:0] last_rd [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] init_byte(input int a);
        case (a)
            8:  return 8'h11;
            9:  return 8'h22;
            10: return 8'h33;
            11: return 8'h44;
            default: return 8'(a * 7 + 3) ^ 8'h5C;
        endcase
    endfunction

    // Behavioural memory: combinational read, one write per mem_wr cycle.
    assign mem_rdata = mem_rd ? mem_words[mem_addr[4:2]] : 32'hA5A5_5A5A;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 8; i++)
                mem_words[i] <= {init_byte(4*i), init_byte(4*i+1), init_byte(4*i+2), init_byte(4*i+3)};
        end else if (mem_wr) begin
            mem_words[mem_addr[4:2]] <= mem_wdata;
            last_wr_addr <= mem_addr;
            last_wr_data <= mem_wdata;
            wr_count     <= wr_count + 1;
        end
    end

    function automatic logic is_err(input logic [1:0] size, input logic [4:0] addr);
        return (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
    endfunction

    function automatic int lat_of(input logic we, input logic [1:0] size, input logic [4:0] addr);
        if (is_err(size, addr)) return 1;
        if (!we || size == 2'd2) return 2;
        return 3;
    endfunction

    // Reference access on the byte-array image (big-endian).
    function automatic res_t ref_access(input logic we, input logic [1:0] size,
                                        input logic [4:0] addr, input logic [31:0] wdata);
        res_t r;
        int a;
        a = int'(addr);
        r.data = 32'd0;
        r.err  = is_err(size, addr);
        r.lat  = lat_of(we, size, addr);
        if (!r.err) begin
            if (!we) begin
                case (size)
                    2'd0:    r.data = {24'd0, ref_mem[a]};
                    2'd1:    r.data = {16'd0, ref_mem[a], ref_mem[a+1]};
                    default: r.data = {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
                endcase
            end else begin
                case (size)
                    2'd0: ref_mem[a] = wdata[7:0];
                    2'd1: begin ref_mem[a] = wdata[15:8]; ref_mem[a+1] = wdata[7:0]; end
                    default: begin
                        ref_mem[a]   = wdata[31:24]; ref_mem[a+1] = wdata[23:16];
                        ref_mem[a+2] = wdata[15:8];  ref_mem[a+3] = wdata[7:0];
                    end
                endcase
            end
        end
        return r;
    endfunction

    // Drive one request, wait for its grant, push the expected response.
    task automatic issue(input int who, input logic we, input logic [1:0] size,
                         input logic [4:0] addr, input logic [31:0] wdata);
        bit   done;
        res_t r;
        exp_t e;
        done = 1'b0;
        if (who == 0) begin
            cpu_we = we; cpu_size = size; cpu_addr = addr; cpu_wdata = wdata; cpu_valid = 1'b1;
        end else begin
            ext_we = we; ext_size = size; ext_addr = addr; ext_wdata = wdata; ext_valid = 1'b1;
        end
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if ((who == 0) ? cpu_ready : ext_ready) done = 1'b1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL accept_timeout req%0d: no ready within 200 cycles", who);
        end else begin
            r = ref_access(we, size, addr, wdata);
            e.data = r.data; e.err = r.err; e.cyc = cyc + r.lat;
            if (who == 0) q_cpu.push_back(e); else q_ext.push_back(e);
            acc_cyc[who] = cyc;
            n_acc[who]++;
        end
        @(posedge clk); #1;
        if (who == 0) cpu_valid = 1'b0; else ext_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(posedge clk);
            if (q_cpu.size() == 0 && q_ext.size() == 0 && cyc > idle_at + 1) done = 1'b1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL drain_timeout: cpu_q=%0d ext_q=%0d", q_cpu.size(), q_ext.size());
        end
        #1;
    endtask

    task automatic resp_check(input int who, input logic v, input logic e, input logic [31:0] d);
        exp_t x;
        string nm;
        nm = (who == 0) ? "cpu" : "ext";
        if (v) begin
            if ((who == 0 && q_cpu.size() == 0) || (who == 1 && q_ext.size() == 0)) begin
                checks++; errors++;
                $display("FAIL %s_unexpected_resp: got resp_valid=1 expected none", nm);
            end else begin
                x = (who == 0) ? q_cpu.pop_front() : q_ext.pop_front();
                check({nm, "_rdata"}, d, x.data);
                check({nm, "_resp_err"}, 32'(e), 32'(x.err));
                check({nm, "_resp_cycle"}, 32'(cyc), 32'(x.cyc));
                last_rd[who] = x.data;
            end
        end else begin
            check({nm, "_rdata_hold"}, d, last_rd[who]);
            check({nm, "_err_unqualified"}, 32'(e), 32'd0);
        end
    endtask

    // Monitor: memory-port invariants, arbitration model, response scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            idle_at = 0; starve = 0; prev_wr = 1'b0;
            last_rd[0] = 32'd0; last_rd[1] = 32'd0;
        end else begin
            bit busy, exp_c, exp_e;
            check("mem_rd_wr_exclusive", 32'(mem_rd & mem_wr), 32'd0);
            check("mem_wr_single_cycle", 32'(prev_wr & mem_wr), 32'd0);
            if (mem_rd || mem_wr) check("mem_addr_aligned", 32'(mem_addr[1:0]), 32'd0);
            prev_wr = mem_wr;
            busy  = (cyc < idle_at);
            exp_e = !busy && ext_valid && (!cpu_valid || starve == int'(LIMIT));
            exp_c = !busy && cpu_valid && !exp_e;
            check("cpu_ready", 32'(cpu_ready), 32'(exp_c));
            check("ext_ready", 32'(ext_ready), 32'(exp_e));
            if (exp_e)      idle_at = cyc + lat_of(ext_we, ext_size, ext_addr) + 1;
            else if (exp_c) idle_at = cyc + lat_of(cpu_we, cpu_size, cpu_addr) + 1;
            if (!ext_valid || exp_e) starve = 0;
            else if (exp_c && starve < int'(LIMIT)) starve++;
            resp_check(0, cpu_resp_valid, cpu_resp_err, cpu_rdata);
            resp_check(1, ext_resp_valid, ext_resp_err, ext_rdata);
        end
    end

    function automatic logic [1:0] rsize();
        return ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int wc;
        int ext_after;
        for (int i = 0; i < 32; i++) ref_mem[i] = init_byte(i);
        n_acc[0] = 0; n_acc[1] = 0; acc_cyc[0] = 0; acc_cyc[1] = 0;
        rst = 1'b0; preload = 1'b1;
        cpu_valid = 1'b1; cpu_we = 1'b0; cpu_size = 2'd2; cpu_addr = '0; cpu_wdata = '0;
        ext_valid = 1'b0; ext_we = 1'b0; ext_size = 2'd0; ext_addr = '0; ext_wdata = '0;
        @(posedge clk); @(posedge clk);
        preload = 1'b0;
        #2;
        check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        check("rst_ext_ready", 32'(ext_ready), 32'd0);
        check("rst_cpu_resp_valid", 32'(cpu_resp_valid), 32'd0);
        check("rst_ext_resp_valid", 32'(ext_resp_valid), 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_ext_rdata", ext_rdata, 32'd0);
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        cpu_valid = 1'b0;
        @(posedge clk); #3 rst = 1'b1;
        @(posedge clk); #1;

        // Word store then word load at 0x04.
        issue(0, 1'b1, 2'd2, 5'h04, 32'hDEADBEEF);
        issue(0, 1'b0, 2'd2, 5'h04, 32'd0);
        wait_drain();
        check("word_store_wr_addr", 32'(last_wr_addr), 32'h04);
        check("word_store_wr_data", last_wr_data, 32'hDEADBEEF);

        // Byte RMW store into 0x11223344 at 0x08, then read back.
        issue(0, 1'b1, 2'd0, 5'h0A, 32'h000000AA);
        wait_drain();
        check("rmw_wr_addr", 32'(last_wr_addr), 32'h08);
        check("rmw_wr_data", last_wr_data, 32'h1122AA44);
        issue(0, 1'b0, 2'd0, 5'h0A, 32'd0);

        // Misaligned accesses: error responses, no write.
        wait_drain();
        wc = wr_count;
        issue(0, 1'b0, 2'd1, 5'h09, 32'd0);
        issue(0, 1'b1, 2'd2, 5'h06, 32'h12345678);
        wait_drain();
        check("err_store_no_write", 32'(wr_count), 32'(wc));

        // Simultaneous requests: CPU first, ext in the IDLE right after CPU's response.
        fork
            issue(0, 1'b0, 2'd2, 5'h04, 32'd0);
            issue(1, 1'b0, 2'd0, 5'h0A, 32'd0);
        join
        check("ext_after_cpu_resp", 32'(acc_cyc[1]), 32'(acc_cyc[0] + 3));
        wait_drain();

        // Starvation: CPU valid continuously, ext wins the arbitration after LIMIT losses.
        n_acc[0] = 0;
        ext_after = -1;
        fork
            for (int i = 0; i < 6; i++) issue(0, 1'b0, 2'd2, 5'($urandom_range(0, 7) * 4), 32'd0);
            begin
                issue(1, 1'b0, 2'd2, 5'h0C, 32'd0);
                ext_after = n_acc[0];
            end
        join
        check("starve_ext_wins_after", 32'(ext_after), 32'(LIMIT));
        wait_drain();

        // Randomized concurrent traffic from both requesters.
        fork
            for (int i = 0; i < 40; i++) begin
                int g;
                g = $urandom_range(0, 2);
                if (g > 0) begin repeat (g) @(posedge clk); #1; end
                issue(0, 1'($urandom), rsize(), 5'($urandom), $urandom);
            end
            for (int i = 0; i < 40; i++) begin
                int g;
                g = $urandom_range(0, 3);
                if (g > 0) begin repeat (g) @(posedge clk); #1; end
                issue(1, 1'($urandom), rsize(), 5'($urandom), $urandom);
            end
        join
        wait_drain();

        // Reset during WR of an RMW store: abort, no response, memory unchanged.
        cpu_we = 1'b1; cpu_size = 2'd0; cpu_addr = 5'h11; cpu_wdata = 32'h0000005A; cpu_valid = 1'b1;
        @(negedge clk);
        check("rmw_abort_accept", 32'(cpu_ready), 32'd1);
        @(posedge clk); #1 cpu_valid = 1'b0;
        @(posedge clk); #2;
        check("rmw_abort_in_wr", 32'(mem_wr), 32'd1);
        rst = 1'b0;
        #1;
        check("abort_mem_wr", 32'(mem_wr), 32'd0);
        check("abort_mem_rd", 32'(mem_rd), 32'd0);
        check("abort_mem_addr", 32'(mem_addr), 32'd0);
        check("abort_mem_wdata", mem_wdata, 32'd0);
        check("abort_cpu_rdata", cpu_rdata, 32'd0);
        @(posedge clk); @(posedge clk); #3 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        issue(0, 1'b0, 2'd2, 5'h10, 32'd0);
        wait_drain();
        check("final_cpu_queue_empty", 32'(q_cpu.size()), 32'd0);
        check("final_ext_queue_empty", 32'(q_ext.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester controller for the byte-addressed, big-endian data memory, which has a combinational read and a single write port.
- Requester 0 is the CPU load/store path. Requester 1 is the external port, used by the debug loader or test DMA.
- The block arbitrates between the two, sequences each access, and performs read-modify-write for byte and halfword stores.
- It sits between the requesters and the memory's addr/rd/wr/wdata/rdata port.

Parameters:
- ADDR_W, 5, byte-address width; matches a 32-entry memory.
- STARVE_LIMIT, 4, consecutive lost arbitrations after which requester 1 is forced to win; range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- cpu_valid  input  1  CPU request present; held until accepted
- cpu_ready  output  1  CPU request accepted this cycle
- cpu_we  input  1  1 = store, 0 = load
- cpu_size  input  2  0 = byte, 1 = halfword, 2 = word; 3 is illegal
- cpu_addr  input  ADDR_W  byte address
- cpu_wdata  input  32  store data, right-aligned for sub-word sizes
- cpu_resp_valid  output  1  one-cycle completion pulse
- cpu_resp_err  output  1  misaligned or illegal size; qualified by cpu_resp_valid
- cpu_rdata  output  32  load data, zero-extended, right-aligned
- ext_valid, ext_ready, ext_we, ext_size, ext_addr, ext_wdata, ext_resp_valid, ext_resp_err, ext_rdata: same as the cpu_* ports, for requester 1
- mem_addr  output  ADDR_W  word-aligned address; low 2 bits always 0
- mem_rd  output  1  memory read enable
- mem_wr  output  1  memory write enable; exactly one cycle per write
- mem_wdata  output  32  full write word
- mem_rdata  input  32  memory read word, valid combinationally while mem_rd = 1

Behaviour:
- Reset: state IDLE. All outputs 0: ready, resp_valid, resp_err, rdata, mem_addr, mem_rd, mem_wr, mem_wdata. Starvation counter 0.
- Reset asserted mid-operation aborts the access. No resp_valid is issued and mem_wr drops at once. A partially done RMW leaves memory unchanged.
- States: IDLE, RD, RMW_RD, WR, RESP.
- IDLE:
  - Winner selection: if exactly one requester is valid, it wins. If both are valid, CPU wins unless starve_cnt == STARVE_LIMIT, in which case ext wins.
  - The winner's ready is driven combinationally high this cycle. Request fields are latched at the edge.
- Starvation counter: increments when ext_valid = 1 and ext loses. It clears when ext is granted or ext_valid = 0, and saturates at STARVE_LIMIT.
- Next state from IDLE, by request type:
  - Error (size = 3; halfword with addr[0] = 1; word with addr[1:0] != 0): RESP with resp_err = 1. No memory access.
  - Load: RD.
  - Word store: WR.
  - Byte or halfword store: RMW_RD.
- RD:
  - mem_addr = {addr[ADDR_W-1:2], 2'b00}, mem_rd = 1.
  - The selected lane is captured at the edge. Byte lane k = addr[1:0], stored in bits [31-8k : 24-8k]. The halfword at addr[1] = 0 is bits 31:16; at addr[1] = 1 it is bits 15:0.
  - Next state RESP.
- RMW_RD:
  - mem_rd = 1; the full word is latched.
  - The store data is merged into the latched word at the lane above; all other bytes are unchanged.
  - Next state WR.
- WR: mem_wr = 1 for one cycle with mem_wdata = merged or full word. mem_rd = 0. Next state RESP.
- RESP:
  - The owner's resp_valid = 1 for one cycle; resp_err as determined in IDLE.
  - rdata holds the load value (0 for stores and errors) and stays stable until the next response to that requester.
  - Next state IDLE.
- Latency from the accept cycle T: load resp at T+2; word store resp at T+2; sub-word store resp at T+3; error resp at T+1.
- Throughput: at most one access in flight. A new accept is possible only in IDLE.
- The non-owner's ready stays 0 for the whole access. Its request must stay stable while its valid is held.
- mem_rd and mem_wr are never both 1.

Test Plan:
- Reset deasserted. CPU word store addr 0x04, data 0xDEADBEEF, then a word load from 0x04 -> mem_wr pulse of exactly 1 cycle at mem_addr 0x04; load resp at T+2 with cpu_rdata = 0xDEADBEEF, err = 0.
- Memory word 0x11223344 at 0x08. Byte store 0xAA to addr 0x0A -> RMW_RD then WR; mem_wdata = 0x1122AA44; resp at T+3. A byte load from 0x0A then returns 0x000000AA.
- Halfword load from 0x09 -> resp at T+1 with err = 1. Word store to 0x06 -> err = 1 and mem_wr never asserts.
- CPU valid every cycle and ext held valid, STARVE_LIMIT = 4 -> CPU wins 4 arbitrations, then ext wins the 5th; counter returns to 0 afterward.
- rst driven low during WR of an RMW store -> outputs 0 asynchronously and no resp_valid. After release, a load of that word returns the pre-store value.
- Both requesters valid while starve_cnt = 0 -> cpu_ready = 1 and ext_ready = 0 in the same cycle. ext is accepted in the first IDLE after the CPU's RESP.
